// File: rtl/alu_exec_unit.sv
// ALU execution unit: single-cycle arithmetic/logic ops plus an iterative
// one-bit-per-cycle shifter behind a start/busy/done handshake, with registered NZCV flags.
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [3:0]       alu_control_i,
  input  logic [1:0]       flag_w_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [4:0]       shamt_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             result_we_o,
  output logic [3:0]       flags_o,
  output logic             illegal_o
);

  typedef enum logic {IDLE, SHIFT} state_t;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_ORR = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_NOT = 4'b0101;
  localparam logic [3:0] OP_LSL = 4'b0111;
  localparam logic [3:0] OP_LSR = 4'b1000;
  localparam logic [3:0] OP_ASR = 4'b1001;
  localparam logic [3:0] OP_ROR = 4'b1010;
  localparam logic [3:0] OP_CMP = 4'b1011;

  state_t           state_q;
  logic             busy_q, done_q, we_q, ill_q;
  logic [WIDTH-1:0] result_q, sh_q;
  logic [3:0]       flags_q, op_q;
  logic [1:0]       fw_q;
  logic [4:0]       count_q;

  // NZ and CV groups are written independently under the flag-write mask.
  function automatic logic [3:0] merge_flags(input logic [3:0] old, input logic [WIDTH-1:0] r,
                                             input logic c, input logic v, input logic [1:0] fw);
    logic [3:0] f;
    f = old;
    if (fw[1]) f[3:2] = {r[WIDTH-1], (r == '0)};
    if (fw[0]) f[1:0] = {c, v};
    return f;
  endfunction

  logic [WIDTH:0]   sum, diff;
  logic [WIDTH-1:0] ex_res;
  logic             ex_c, ex_v, ex_ill, ex_shift;

  assign sum  = {1'b0, a_i} + {1'b0, b_i};
  assign diff = {1'b0, a_i} - {1'b0, b_i};

  always_comb begin
    ex_res   = '0;
    ex_c     = flags_q[1];
    ex_v     = flags_q[0];
    ex_ill   = 1'b0;
    ex_shift = 1'b0;
    case (alu_control_i)
      OP_ADD: begin
        ex_res = sum[WIDTH-1:0];
        ex_c   = sum[WIDTH];
        ex_v   = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]);
      end
      OP_SUB, OP_CMP: begin
        ex_res = diff[WIDTH-1:0];
        ex_c   = ~diff[WIDTH];
        ex_v   = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (diff[WIDTH-1] != a_i[WIDTH-1]);
      end
      OP_AND: begin ex_res = a_i & b_i; ex_c = 1'b0; ex_v = 1'b0; end
      OP_ORR: begin ex_res = a_i | b_i; ex_c = 1'b0; ex_v = 1'b0; end
      OP_XOR: begin ex_res = a_i ^ b_i; ex_c = 1'b0; ex_v = 1'b0; end
      OP_NOT: begin ex_res = ~b_i;      ex_c = 1'b0; ex_v = 1'b0; end
      // Zero-amount shifts pass b through and keep the current carry.
      OP_LSL, OP_LSR, OP_ASR, OP_ROR: begin
        ex_res   = b_i;
        ex_shift = 1'b1;
      end
      default: ex_ill = 1'b1;
    endcase
  end

  logic [WIDTH-1:0] step_res;
  logic             step_c;

  always_comb begin
    step_res = sh_q;
    step_c   = flags_q[1];
    case (op_q)
      OP_LSL: begin step_res = {sh_q[WIDTH-2:0], 1'b0};        step_c = sh_q[WIDTH-1]; end
      OP_LSR: begin step_res = {1'b0, sh_q[WIDTH-1:1]};        step_c = sh_q[0]; end
      OP_ASR: begin step_res = {sh_q[WIDTH-1], sh_q[WIDTH-1:1]}; step_c = sh_q[0]; end
      OP_ROR: begin step_res = {sh_q[0], sh_q[WIDTH-1:1]};     step_c = sh_q[0]; end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      we_q     <= 1'b0;
      ill_q    <= 1'b0;
      result_q <= '0;
      flags_q  <= '0;
      sh_q     <= '0;
      op_q     <= '0;
      fw_q     <= '0;
      count_q  <= '0;
    end else begin
      done_q <= 1'b0;
      we_q   <= 1'b0;
      ill_q  <= 1'b0;
      case (state_q)
        IDLE: if (start_i) begin
          if (ex_shift && shamt_i != 5'd0) begin
            sh_q    <= b_i;
            op_q    <= alu_control_i;
            fw_q    <= flag_w_i;
            count_q <= shamt_i;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end else begin
            result_q <= ex_res;
            if (!ex_ill) flags_q <= merge_flags(flags_q, ex_res, ex_c, ex_v, flag_w_i);
            done_q   <= 1'b1;
            we_q     <= ~ex_ill && (alu_control_i != OP_CMP);
            ill_q    <= ex_ill;
          end
        end
        SHIFT: begin
          sh_q    <= step_res;
          count_q <= count_q - 5'd1;
          if (count_q == 5'd1) begin
            result_q <= step_res;
            flags_q  <= merge_flags(flags_q, step_res, step_c, flags_q[0], fw_q);
            done_q   <= 1'b1;
            we_q     <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign result_o    = result_q;
  assign result_we_o = we_q;
  assign flags_o     = flags_q;
  assign illegal_o   = ill_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed plus randomized bench for alu_exec_unit against an arithmetic reference model.
module tb_alu_exec_unit;
  logic        clk = 1'b0;
  logic        reset, start;
  logic [3:0]  alu_control;
  logic [1:0]  flag_w;
  logic [31:0] a, b;
  logic [4:0]  shamt;
  logic        busy, done, result_we, illegal;
  logic [31:0] result;
  logic [3:0]  flags;

  int checks = 0;
  int errors = 0;
  logic [3:0] m_flags;

  alu_exec_unit #(.WIDTH(32)) dut (
    .clk_i(clk), .reset_i(reset), .start_i(start), .alu_control_i(alu_control),
    .flag_w_i(flag_w), .a_i(a), .b_i(b), .shamt_i(shamt),
    .busy_o(busy), .done_o(done), .result_o(result), .result_we_o(result_we),
    .flags_o(flags), .illegal_o(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: result, write-enable, illegal, latency; updates m_flags.
  task automatic model(input logic [3:0] op, input logic [1:0] fw, input logic [31:0] ia,
                       input logic [31:0] ib, input logic [4:0] sh, output logic [31:0] r,
                       output logic we, output logic ill, output int lat);
    longint s;
    logic [63:0] x;
    logic signed [63:0] xs;
    logic c, v;
    longint maxs = 2147483647;
    longint mins = -longint'(2147483647) - 1;
    c = m_flags[1]; v = m_flags[0]; ill = 1'b0; lat = 1; r = 32'h0;
    case (op)
      4'd0: begin
        r = ia + ib; c = ({32'h0, ia} + {32'h0, ib}) > 64'hFFFF_FFFF;
        s = longint'($signed(ia)) + longint'($signed(ib)); v = (s > maxs) || (s < mins);
      end
      4'd1, 4'd11: begin
        r = ia - ib; c = (ia >= ib);
        s = longint'($signed(ia)) - longint'($signed(ib)); v = (s > maxs) || (s < mins);
      end
      4'd2: begin r = ia & ib; c = 0; v = 0; end
      4'd3: begin r = ia | ib; c = 0; v = 0; end
      4'd4: begin r = ia ^ ib; c = 0; v = 0; end
      4'd5: begin r = ~ib;     c = 0; v = 0; end
      4'd7, 4'd8, 4'd9, 4'd10: begin
        r = ib;
        if (sh != 0) begin
          lat = int'(sh) + 1;
          case (op)
            4'd7:  begin x = {32'h0, ib} << sh; r = x[31:0]; c = x[32]; end
            4'd8:  begin x = {ib, 32'h0} >> sh; r = x[63:32]; c = x[31]; end
            4'd9:  begin xs = $signed({ib, 32'h0}) >>> sh; r = xs[63:32]; c = xs[31]; end
            default: begin r = (ib >> sh) | (ib << (32 - int'(sh))); c = r[31]; end
          endcase
        end
      end
      default: ill = 1'b1;
    endcase
    if (!ill) begin
      if (fw[1]) m_flags[3:2] = {r[31], r == 32'h0};
      if (fw[0]) m_flags[1:0] = {c, v};
    end
    we = !ill && (op != 4'd11);
  endtask

  // Issue one op, scramble inputs after acceptance, check busy/latency/outputs.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [1:0] fw,
                        input logic [31:0] ia, input logic [31:0] ib, input logic [4:0] sh,
                        input bit hold_start);
    logic [31:0] er; logic ewe, eill; int elat; int lat;
    model(op, fw, ia, ib, sh, er, ewe, eill, elat);
    @(negedge clk);
    alu_control = op; flag_w = fw; a = ia; b = ib; shamt = sh; start = 1'b1;
    lat = 0;
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      @(negedge clk);
      if (!hold_start) start = 1'b0;
      a = $urandom; b = $urandom; shamt = 5'($urandom); flag_w = 2'($urandom);
      alu_control = 4'($urandom);
      if (done) lat = k;
      else if (k < elat) chk({tag, " busy"}, 32'(busy), 32'd1);
    end
    start = 1'b0;
    chk({tag, " latency"}, lat, elat);
    chk({tag, " busy@done"}, 32'(busy), 32'd0);
    chk({tag, " result"}, result, er);
    chk({tag, " we"}, 32'(result_we), 32'(ewe));
    chk({tag, " illegal"}, 32'(illegal), 32'(eill));
    chk({tag, " flags"}, 32'(flags), 32'(m_flags));
    @(negedge clk);
    chk({tag, " done pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    logic [31:0] er; logic ewe, eill; int elat; int ndone;
    reset = 1'b1; start = 1'b0; alu_control = '0; flag_w = '0; a = '0; b = '0; shamt = '0;
    m_flags = 4'h0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst busy", 32'(busy), 0); chk("rst done", 32'(done), 0);
    chk("rst result", result, 0); chk("rst flags", 32'(flags), 0);
    chk("rst illegal", 32'(illegal), 0); chk("rst we", 32'(result_we), 0);

    run_op("add ovf", 4'd0, 2'b11, 32'h7FFF_FFFF, 32'h1, 5'd0, 0);
    chk("add ovf flags const", 32'(flags), 32'h9);
    run_op("cmp eq", 4'd11, 2'b11, 32'd5, 32'd5, 5'd0, 0);
    chk("cmp flags const", 32'(flags), 32'h6);
    run_op("ands", 4'd2, 2'b10, 32'hF0, 32'h0F, 5'd0, 0);
    chk("ands flags const", 32'(flags), 32'h6);
    run_op("asr4", 4'd9, 2'b11, 32'h0, 32'h8000_0001, 5'd4, 0);
    chk("asr result const", result, 32'hF800_0000);
    run_op("ror1", 4'd10, 2'b11, 32'h0, 32'h0000_0001, 5'd1, 0);
    chk("ror result const", result, 32'h8000_0000);
    run_op("lsr31 hold", 4'd8, 2'b11, 32'h0, 32'hDEAD_BEEF, 5'd31, 1);
    run_op("lsl0", 4'd7, 2'b11, 32'h0, 32'h1234_5678, 5'd0, 0);

    // Back-to-back single-cycle ops: start held through the done cycle.
    @(negedge clk);
    alu_control = 4'd0; flag_w = 2'b11; a = 32'd10; b = 32'd20; start = 1'b1;
    @(negedge clk);
    chk("b2b done1", 32'(done), 1); chk("b2b res1", result, 32'd30);
    alu_control = 4'd1; a = 32'd3; b = 32'd4;
    @(negedge clk);
    start = 1'b0;
    chk("b2b done2", 32'(done), 1); chk("b2b res2", result, 32'hFFFF_FFFF);
    chk("b2b flags2", 32'(flags), 32'h8);
    m_flags = 4'h8;

    // Reset during a shift aborts it.
    @(negedge clk);
    alu_control = 4'd8; flag_w = 2'b11; b = 32'hFFFF_0000; shamt = 5'd10; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    chk("abort busy", 32'(busy), 0); chk("abort result", result, 0);
    chk("abort flags", 32'(flags), 0); chk("abort done", 32'(done), 0);
    m_flags = 4'h0;
    ndone = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("abort no done", ndone, 0);

    run_op("setflags", 4'd1, 2'b11, 32'd1, 32'd2, 5'd0, 0);
    run_op("illegal", 4'd12, 2'b11, 32'h5, 32'h6, 5'd3, 0);

    for (int i = 0; i < 60; i++) begin
      logic [3:0] op; logic [4:0] sh;
      op = 4'($urandom_range(0, 15));
      sh = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      run_op("rand", op, 2'($urandom), $urandom, $urandom, sh, bit'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
